acs_state_update_unit: RTL and testbench

- Sequential add-compare-select (ACS) engine that produces the per-state energies and survivor histories consumed by the sequence detector's state-selection logic.
- Each accepted set of branch energies updates all N_S state metrics by iterating over predecessors.
- After the update it normalizes the metrics and presents registered energies and histories with a one-cycle valid pulse.

---
 rtl/acs_state_update_unit.sv | 133 +++++++++++++
 tb/tb_acs_state_update_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_state_update_unit.sv
`default_nettype none
// ============================================================================
//  Module      : acs_state_update_unit
//  Description : Sequential add-compare-select engine. It updates the trellis
//                state metrics and survivor histories, one predecessor per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module acs_state_update_unit #(
  parameter int N_S     = 4,
  parameter int H_DEPTH = 4,
  parameter int B_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [N_S-1:0][1:0]                     state_symbols,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [N_S-1:0][N_S-1:0][B_WIDTH-1:0]    branch_energies,
  output logic                                    out_valid,
  output logic [N_S-1:0][2*B_WIDTH-1:0]           state_energies,
  output logic [N_S-1:0][H_DEPTH-1:0][1:0]        state_histories
);

  localparam int EW = 2 * B_WIDTH;
  localparam int PW = (N_S > 1) ? $clog2(N_S) : 1;
  localparam logic [PW-1:0] c_P_LAST = PW'(N_S - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_ACS  = 2'd1;
  localparam logic [1:0] c_S_NORM = 2'd2;
  localparam logic [1:0] c_S_OUT  = 2'd3;

  logic [1:0]                              r_state;
  logic [PW-1:0]                           r_p;
  logic [N_S-1:0][N_S-1:0][B_WIDTH-1:0]    r_br;
  logic [N_S-1:0][EW-1:0]                  r_best;
  logic [N_S-1:0][PW-1:0]                  r_bp;
  logic [N_S-1:0][EW-1:0]                  r_energy;
  logic [N_S-1:0][H_DEPTH-1:0][1:0]        r_hist;

  logic [N_S-1:0][EW-1:0]                  w_cand;
  logic [EW-1:0]                           w_min;
  logic [N_S-1:0][H_DEPTH-1:0][1:0]        w_hist_nxt;

  // Branch cost is zero-extended; a carry out clamps to the all-ones metric.
  function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] a, input logic [B_WIDTH-1:0] b);
    logic [EW:0] s;
    s = {1'b0, a} + {{(B_WIDTH + 1){1'b0}}, b};
    return s[EW] ? {EW{1'b1}} : s[EW-1:0];
  endfunction

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < N_S; i++) begin
      w_cand[i] = sat_add(r_energy[r_p], r_br[r_p][i]);
    end
  end

  always_comb begin
    w_min = r_best[0];
    for (int i = 1; i < N_S; i++) begin
      if (r_best[i] < w_min) w_min = r_best[i];
    end
  end

  // New history: own symbol in front of the winning predecessor's old history.
  always_comb begin
    w_hist_nxt = '0;
    for (int i = 0; i < N_S; i++) begin
      w_hist_nxt[i][0] = state_symbols[i];
      for (int k = 1; k < H_DEPTH; k++) begin
        w_hist_nxt[i][k] = r_hist[r_bp[i]][k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state  <= c_S_IDLE;
      r_p      <= '0;
      r_br     <= '0;
      r_best   <= '0;
      r_bp     <= '0;
      r_energy <= '0;
      r_hist   <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (in_valid) begin
            r_br    <= branch_energies;
            r_p     <= '0;
            r_state <= c_S_ACS;
          end
        end
        c_S_ACS: begin
          // Strict compare keeps the lowest predecessor index on ties.
          for (int i = 0; i < N_S; i++) begin
            if ((r_p == '0) || (w_cand[i] < r_best[i])) begin
              r_best[i] <= w_cand[i];
              r_bp[i]   <= r_p;
            end
          end
          if (r_p == c_P_LAST) begin
            r_state <= c_S_NORM;
          end else begin
            r_p <= r_p + 1'b1;
          end
        end
        c_S_NORM: begin
          for (int i = 0; i < N_S; i++) begin
            r_energy[i] <= r_best[i] - w_min;
          end
          r_hist  <= w_hist_nxt;
          r_state <= c_S_OUT;
        end
        c_S_OUT: begin
          r_state <= c_S_IDLE;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  assign in_ready        = (r_state == c_S_IDLE);
  assign out_valid       = (r_state == c_S_OUT);
  assign state_energies  = r_energy;
  assign state_histories = r_hist;

endmodule
`default_nettype wire

// File: tb/tb_acs_state_update_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acs_state_update_unit
//  Description : Directed bench with a reference-model scoreboard. It drives an
//                N_S=2 instance and an N_S=4 instance of the ACS unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acs_state_update_unit;

  localparam logic [1:0] c_NEG = 2'b11;
  localparam logic [1:0] c_POS = 2'b01;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                    flush2, iv2, ir2, ov2;
  logic [1:0][1:0]         sym2;
  logic [1:0][1:0][7:0]    br2;
  logic [1:0][15:0]        se2;
  logic [1:0][3:0][1:0]    sh2;

  logic                    flush4, iv4, ir4, ov4;
  logic [3:0][1:0]         sym4;
  logic [3:0][3:0][7:0]    br4;
  logic [3:0][15:0]        se4;
  logic [3:0][3:0][1:0]    sh4;

  acs_state_update_unit #(.N_S(2), .H_DEPTH(4), .B_WIDTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .state_symbols(sym2),
    .in_valid(iv2), .in_ready(ir2), .branch_energies(br2),
    .out_valid(ov2), .state_energies(se2), .state_histories(sh2)
  );

  acs_state_update_unit #(.N_S(4), .H_DEPTH(4), .B_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .state_symbols(sym4),
    .in_valid(iv4), .in_ready(ir4), .branch_energies(br4),
    .out_valid(ov4), .state_energies(se4), .state_histories(sh4)
  );

  typedef struct packed {
    logic [3:0][15:0] e;
    logic [3:0][7:0]  h;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         mE [2][4];
  logic [1:0] mH [2][4][4];
  int         tbr [4][4];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int nst(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic logic ov(input int d);
    return (d == 0) ? ov2 : ov4;
  endfunction

  function automatic logic ir(input int d);
    return (d == 0) ? ir2 : ir4;
  endfunction

  function automatic logic [15:0] ge(input int d, input int i);
    return (d == 0) ? se2[i[0]] : se4[i[1:0]];
  endfunction

  function automatic logic [7:0] gh(input int d, input int i);
    return (d == 0) ? sh2[i[0]] : sh4[i[1:0]];
  endfunction

  task automatic set_iv(input int d, input logic v);
    if (d == 0) iv2 = v; else iv4 = v;
  endtask

  task automatic apply_br(input int d);
    for (int p = 0; p < nst(d); p++)
      for (int i = 0; i < nst(d); i++)
        if (d == 0) br2[p[0]][i[0]] = 8'(tbr[p][i]);
        else        br4[p[1:0]][i[1:0]] = 8'(tbr[p][i]);
  endtask

  task automatic junk_br(input int d);
    if (d == 0) br2 = $urandom;
    else        br4 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 4; i++) begin
      mE[d][i] = 0;
      for (int k = 0; k < 4; k++) mH[d][i][k] = 2'b00;
    end
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  // Reference ACS update; pushes the expected outputs onto the scoreboard.
  task automatic model_step(input int d);
    int n, mn, cand;
    int best [4];
    int bp [4];
    logic [1:0] nh [4][4];
    exp_t x;
    n = nst(d);
    x = '0;
    for (int i = 0; i < n; i++) begin
      best[i] = 0;
      bp[i] = 0;
      for (int p = 0; p < n; p++) begin
        cand = mE[d][p] + tbr[p][i];
        if (cand > 65535) cand = 65535;
        if (p == 0 || cand < best[i]) begin
          best[i] = cand;
          bp[i] = p;
        end
      end
    end
    mn = best[0];
    for (int i = 1; i < n; i++) if (best[i] < mn) mn = best[i];
    for (int i = 0; i < n; i++) begin
      nh[i][0] = (d == 0) ? sym2[i[0]] : sym4[i[1:0]];
      for (int k = 1; k < 4; k++) nh[i][k] = mH[d][bp[i]][k-1];
    end
    for (int i = 0; i < n; i++) begin
      mE[d][i] = best[i] - mn;
      x.e[i] = 16'(mE[d][i]);
      for (int k = 0; k < 4; k++) begin
        mH[d][i][k] = nh[i][k];
        x.h[i][2*k +: 2] = nh[i][k];
      end
    end
    if (d == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic compare_out(input int d);
    exp_t x;
    x = '0;
    if (d == 0) begin
      check("sb_depth", q0.size(), 1);
      if (q0.size() > 0) x = q0.pop_front();
    end else begin
      check("sb_depth", q1.size(), 1);
      if (q1.size() > 0) x = q1.pop_front();
    end
    for (int i = 0; i < nst(d); i++) begin
      check($sformatf("energy[%0d][%0d]", d, i), ge(d, i), x.e[i]);
      check($sformatf("history[%0d][%0d]", d, i), gh(d, i), x.h[i]);
    end
  endtask

  // Precondition: positioned at a negedge with the unit idle.
  task automatic do_update(input int d);
    int lat;
    lat = 0;
    check("in_ready_idle", ir(d), 1);
    apply_br(d);
    set_iv(d, 1'b1);
    model_step(d);
    @(posedge clk);
    @(negedge clk);
    set_iv(d, 1'b0);
    junk_br(d);
    for (int k = 1; k <= 20; k++) begin
      if (ov(d)) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("latency", lat, nst(d) + 2);
    if (lat != 0) compare_out(d);
    @(negedge clk);
    check("out_valid_pulse", ov(d), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
  endtask

  task automatic abort_mid(input bit use_rst);
    int cnt;
    apply_br(0);
    iv2 = 1'b1;
    model_step(0);
    void'(q0.pop_back());
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    junk_br(0);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush2 = 1'b1;
    @(negedge clk);
    check("abort_out_valid", ov2, 0);
    check("abort_in_ready", ir2, 1);
    check("abort_energies", se2, 0);
    check("abort_histories", sh2, 0);
    rst = 1'b0;
    flush2 = 1'b0;
    model_reset(0);
    if (use_rst) model_reset(1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov2) cnt++;
    end
    check("abort_no_out", cnt, 0);
  endtask

  task automatic set_s1();
    tbr[0][0] = 5; tbr[1][0] = 3; tbr[0][1] = 2; tbr[1][1] = 7;
  endtask

  task automatic check_s1();
    check("s1_e0", se2[0], 1);
    check("s1_e1", se2[1], 0);
    check("s1_h0", sh2[0], 8'h03);
    check("s1_h1", sh2[1], 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, ovs, c0, c1;
    rst = 1'b1; flush2 = 1'b0; flush4 = 1'b0; iv2 = 1'b0; iv4 = 1'b0;
    br2 = '0; br4 = '0;
    sym2[0] = c_NEG; sym2[1] = c_POS;
    sym4[0] = c_NEG; sym4[1] = c_POS; sym4[2] = 2'b00; sym4[3] = c_NEG;
    for (int p = 0; p < 4; p++) for (int i = 0; i < 4; i++) tbr[p][i] = 0;
    repeat (2) @(posedge clk);
    do_reset();

    check("rst_in_ready2", ir2, 1);
    check("rst_out_valid2", ov2, 0);
    check("rst_energies2", se2, 0);
    check("rst_histories2", sh2, 0);
    check("rst_in_ready4", ir4, 1);
    check("rst_energies4", se4, 0);
    check("rst_histories4", sh4, 0);

    // Basic update, then abort by flush and by reset, each followed by a fresh update.
    set_s1();
    do_update(0);
    check_s1();
    abort_mid(1'b0);
    do_update(0);
    check_s1();
    abort_mid(1'b1);
    do_update(0);
    check_s1();

    // Tie-break: equal costs pick predecessor 0.
    do_reset();
    for (int p = 0; p < 2; p++) for (int i = 0; i < 2; i++) tbr[p][i] = 4;
    do_update(0);
    check("tie1_e", se2, 0);
    check("tie1_h0", sh2[0], 8'h03);
    check("tie1_h1", sh2[1], 8'h01);
    do_update(0);
    check("tie2_h0", sh2[0], 8'h0F);
    check("tie2_h1", sh2[1], 8'h0D);

    // History wrap with self-transitions favoured.
    tbr[0][0] = 0; tbr[1][1] = 0; tbr[0][1] = 9; tbr[1][0] = 9;
    repeat (6) do_update(0);
    check("wrap_e", se2, 0);
    check("wrap_h0", sh2[0], 8'hFF);
    check("wrap_h1", sh2[1], 8'h55);

    // Continuous in_valid; branches change freely outside IDLE.
    acc = 0; ovs = 0; c0 = -1; c1 = -1;
    iv2 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (ov2) begin
        ovs++;
        compare_out(0);
      end
      if (ir2) begin
        if (acc == 0) begin
          c0 = c;
          tbr[0][0] = 1; tbr[1][0] = 6; tbr[0][1] = 3; tbr[1][1] = 2;
        end else begin
          c1 = c;
          tbr[0][0] = 9; tbr[1][0] = 0; tbr[0][1] = 4; tbr[1][1] = 4;
        end
        acc++;
        apply_br(0);
        model_step(0);
      end else begin
        junk_br(0);
      end
      @(negedge clk);
    end
    iv2 = 1'b0;
    check("bp_accepts", acc, 2);
    check("bp_out_count", ovs, 2);
    check("bp_spacing", c1 - c0, 5);
    @(negedge clk);

    // N_S=4: every state prefers predecessor 0.
    for (int p = 0; p < 4; p++) for (int i = 0; i < 4; i++) tbr[p][i] = 10 * i + p;
    do_update(1);
    check("n4_e0", se4[0], 0);
    check("n4_e1", se4[1], 10);
    check("n4_e2", se4[2], 20);
    check("n4_e3", se4[3], 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
